// File: rtl/cheshire_rst_seq_pkg.sv
// Shared types and default timing for the Cheshire FPGA reset/boot sequencer.
package cheshire_rst_seq_pkg;

    typedef enum logic [2:0] {
        RST_RESET      = 3'd0,
        RST_WAIT_LOCK  = 3'd1,
        RST_WAIT_CALIB = 3'd2,
        RST_HOLD       = 3'd3,
        RST_RUN        = 3'd4
    } rst_seq_state_e;

    localparam int unsigned DefDebounceCycles     = 50000;
    localparam int unsigned DefMinRstCycles       = 16;
    localparam int unsigned DefHoldCycles         = 1024;
    localparam int unsigned DefCalibTimeoutCycles = 2**24;
    localparam int unsigned DefCntWidth           = 25;

endpackage

// File: rtl/cheshire_rst_debounce.sv
// Two-flop synchroniser plus stability filter for a raw board button.
module cheshire_rst_debounce
    import cheshire_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned CntWidth       = DefCntWidth
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

    logic [1:0]          sync_q, sync_d;
    logic                deb_q, deb_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                btn_sync;

    assign btn_sync = sync_q[1];

    // The counter only runs while the synced level disagrees with the accepted
    // level, so any bounce back to the accepted level restarts the stability window.
    always_comb begin
        sync_d = {sync_q[0], btn_i};
        deb_d  = deb_q;
        cnt_d  = '0;
        if (btn_sync != deb_q) begin
            if (cnt_q >= CntLast) begin
                deb_d = btn_sync;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_o = deb_q;

endmodule

// File: rtl/cheshire_rst_seq_xilinx.sv
// Board reset/boot sequencer: button debounce, DRAM reset -> lock -> calib -> SoC release.
// Optional calibration timeout/retry enabled by CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN.
module cheshire_rst_seq_xilinx
    import cheshire_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles     = DefDebounceCycles,
    parameter int unsigned MinRstCycles       = DefMinRstCycles,
    parameter int unsigned HoldCycles         = DefHoldCycles,
    parameter int unsigned CalibTimeoutCycles = DefCalibTimeoutCycles,
    parameter int unsigned CntWidth           = DefCntWidth
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_rst_i,
    input  logic       vio_rst_i,
    input  logic       mmcm_locked_i,
    input  logic       calib_done_i,
    input  logic [1:0] boot_mode_i,
    output logic       soc_rst_no,
    output logic       dram_sys_rst_o,
    output logic [1:0] boot_mode_o,
    output logic [2:0] seq_state_o,
    output logic       calib_timeout_o
);

    localparam longint unsigned MaxA = (64'(DebounceCycles) > 64'(MinRstCycles)) ?
                                       64'(DebounceCycles) : 64'(MinRstCycles);
    localparam longint unsigned MaxB = (64'(HoldCycles) > 64'(CalibTimeoutCycles)) ?
                                       64'(HoldCycles) : 64'(CalibTimeoutCycles);
    localparam longint unsigned MaxParam   = (MaxA > MaxB) ? MaxA : MaxB;
    localparam bit              CntWidthOk = (CntWidth >= 64) ||
                                             ((MaxParam + 64'd1) < (64'd1 << CntWidth));

    if (!CntWidthOk) begin : gen_cnt_width_err
        $error("CntWidth is too narrow for the largest cycle parameter");
    end

    localparam logic [CntWidth-1:0] MinRstLast = CntWidth'(MinRstCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(HoldCycles - 1);
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
    localparam logic [CntWidth-1:0] CalibTimeoutLast = CntWidth'(CalibTimeoutCycles - 1);
`endif

    logic [1:0]          lock_sync_q, lock_sync_d;
    logic [1:0]          calib_sync_q, calib_sync_d;
    logic                btn_deb;
    logic                locked_sync, calib_sync, rst_req;
    rst_seq_state_e      state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                soc_rst_n_q, soc_rst_n_d;
    logic                dram_sys_rst_q, dram_sys_rst_d;
    logic [1:0]          boot_mode_q, boot_mode_d;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
    logic                calib_timeout_q, calib_timeout_d;
    logic                timeout_hit;
`endif

    cheshire_rst_debounce #(
        .DebounceCycles (DebounceCycles),
        .CntWidth       (CntWidth)
    ) i_btn_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_rst_i),
        .btn_o  (btn_deb)
    );

    assign locked_sync = lock_sync_q[1];
    assign calib_sync  = calib_sync_q[1];
    // Losing the clock lock is treated like any other reset request.
    assign rst_req     = btn_deb | vio_rst_i | ~locked_sync;

    always_comb begin
        lock_sync_d  = {lock_sync_q[0], mmcm_locked_i};
        calib_sync_d = {calib_sync_q[0], calib_done_i};
        state_d      = state_q;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        if (rst_req) begin
            state_d = RST_RESET;
        end else begin
            case (state_q)
                RST_RESET: begin
                    if (cnt_q >= MinRstLast) state_d = RST_WAIT_LOCK;
                end
                RST_WAIT_LOCK: begin
                    if (locked_sync) state_d = RST_WAIT_CALIB;
                end
                RST_WAIT_CALIB: begin
                    if (calib_sync) begin
                        state_d = RST_HOLD;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
                    end else if (cnt_q == CalibTimeoutLast) begin
                        state_d     = RST_RESET;
                        timeout_hit = 1'b1;
`endif
                    end
                end
                RST_HOLD: begin
                    if (!calib_sync)          state_d = RST_WAIT_CALIB;
                    else if (cnt_q == HoldLast) state_d = RST_RUN;
                end
                RST_RUN: begin
                    if (!calib_sync) state_d = RST_RESET;
                end
                default: state_d = RST_RESET;
            endcase
        end

        // Outputs are decoded from the next state so they change on the transition edge.
        if (state_d != state_q)  cnt_d = '0;
        else if (&cnt_q)         cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CntWidth'(1);

        soc_rst_n_d    = (state_d == RST_RUN);
        dram_sys_rst_d = (state_d == RST_RESET) || (state_d == RST_WAIT_LOCK);
        boot_mode_d    = ((state_q == RST_HOLD) && (state_d == RST_RUN)) ? boot_mode_i : boot_mode_q;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
        if ((state_d == RST_RUN) && (state_q != RST_RUN)) calib_timeout_d = 1'b0;
        else if (timeout_hit)                              calib_timeout_d = 1'b1;
        else                                               calib_timeout_d = calib_timeout_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync_q     <= '0;
            calib_sync_q    <= '0;
            state_q         <= RST_RESET;
            cnt_q           <= '0;
            soc_rst_n_q     <= 1'b0;
            dram_sys_rst_q  <= 1'b1;
            boot_mode_q     <= 2'b00;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
            calib_timeout_q <= 1'b0;
`endif
        end else begin
            lock_sync_q     <= lock_sync_d;
            calib_sync_q    <= calib_sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            soc_rst_n_q     <= soc_rst_n_d;
            dram_sys_rst_q  <= dram_sys_rst_d;
            boot_mode_q     <= boot_mode_d;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
            calib_timeout_q <= calib_timeout_d;
`endif
        end
    end

    assign soc_rst_no     = soc_rst_n_q;
    assign dram_sys_rst_o = dram_sys_rst_q;
    assign boot_mode_o    = boot_mode_q;
    assign seq_state_o    = state_q;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
    assign calib_timeout_o = calib_timeout_q;
`else
    assign calib_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cheshire_rst_seq_xilinx.sv
// Randomised and directed bench for cheshire_rst_seq_xilinx against a timestamp-based reference.
module tb_cheshire_rst_seq_xilinx;

    localparam int D    = 8;
    localparam int M    = 4;
    localparam int H    = 16;
    localparam int T    = 64;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       btn_rst_i = 1'b0;
    logic       vio_rst_i = 1'b0;
    logic       mmcm_locked_i = 1'b0;
    logic       calib_done_i = 1'b0;
    logic [1:0] boot_mode_i = 2'b00;
    logic       soc_rst_no;
    logic       dram_sys_rst_o;
    logic [1:0] boot_mode_o;
    logic [2:0] seq_state_o;
    logic       calib_timeout_o;

    cheshire_rst_seq_xilinx #(
        .DebounceCycles     (D),
        .MinRstCycles       (M),
        .HoldCycles         (H),
        .CalibTimeoutCycles (T),
        .CntWidth           (25)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .btn_rst_i       (btn_rst_i),
        .vio_rst_i       (vio_rst_i),
        .mmcm_locked_i   (mmcm_locked_i),
        .calib_done_i    (calib_done_i),
        .boot_mode_i     (boot_mode_i),
        .soc_rst_no      (soc_rst_no),
        .dram_sys_rst_o  (dram_sys_rst_o),
        .boot_mode_o     (boot_mode_o),
        .seq_state_o     (seq_state_o),
        .calib_timeout_o (calib_timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Input history per clock edge: 0=button, 1=lock, 2=calib.
    bit hist [0:2][0:MAXC-1];
    int base = 0;

    int         m_phase = 0;
    int         m_entered = 0;
    bit         m_deb = 1'b0;
    logic [1:0] m_boot = 2'b00;
    bit         m_tmo = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit h(input int s, input int i);
        if (i < base || i < 0 || i >= MAXC) return 1'b0;
        return hist[s][i];
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_deb     = 1'b0;
        m_boot    = 2'b00;
        m_tmo     = 1'b0;
        base      = cyc + 1;
        m_entered = cyc;
    endtask

    // Evaluate the sequencing rules at edge 'cyc'. Synchronised inputs seen at an
    // edge are the raw values sampled two edges earlier; dwell is the number of
    // edges spent in the current phase before this one.
    task automatic model_edge(input bit vio, input logic [1:0] boot);
        bit lk, cb, req, flip;
        int dwell, nxt;
        lk    = h(1, cyc - 2);
        cb    = h(2, cyc - 2);
        dwell = cyc - 1 - m_entered;
        req   = m_deb | vio | !lk;
        nxt   = m_phase;
        if (req) nxt = 0;
        else if (m_phase == 0) begin
            if (dwell >= M - 1) nxt = 1;
        end else if (m_phase == 1) begin
            nxt = 2;
        end else if (m_phase == 2) begin
            if (cb) nxt = 3;
`ifdef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
            else if (dwell == T - 1) begin
                nxt   = 0;
                m_tmo = 1'b1;
            end
`endif
        end else if (m_phase == 3) begin
            if (!cb) nxt = 2;
            else if (dwell == H - 1) begin
                nxt    = 4;
                m_boot = boot;
            end
        end else if (!cb) begin
            nxt = 0;
        end
        if (nxt == 4 && m_phase != 4) m_tmo = 1'b0;
        if (nxt != m_phase) m_entered = cyc;
        m_phase = nxt;
        // Debounced level flips once the last D synced samples all disagree with it.
        flip = 1'b1;
        for (int k = cyc - D - 1; k <= cyc - 2; k++)
            if (h(0, k) == m_deb) flip = 1'b0;
        if (flip) m_deb = !m_deb;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        hist[0][cyc] = btn_rst_i;
        hist[1][cyc] = mmcm_locked_i;
        hist[2][cyc] = calib_done_i;
        if (!rst_ni) model_reset();
        else         model_edge(vio_rst_i, boot_mode_i);
        @(negedge clk);
        check_eq("state",     seq_state_o,     m_phase);
        check_eq("soc_rst_n", soc_rst_no,      m_phase == 4);
        check_eq("dram_rst",  dram_sys_rst_o,  m_phase <= 1);
        check_eq("boot_mode", boot_mode_o,     m_boot);
        check_eq("calib_tmo", calib_timeout_o, m_tmo);
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic async_reset(input int hold);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("rst_state", seq_state_o,     0);
        check_eq("rst_soc",   soc_rst_no,      0);
        check_eq("rst_dram",  dram_sys_rst_o,  1);
        check_eq("rst_boot",  boot_mode_o,     0);
        check_eq("rst_tmo",   calib_timeout_o, 0);
        run(hold);
        rst_ni = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int k;
        k = 0;
        while (seq_state_o !== target && k < budget) begin
            cycle();
            k++;
        end
        check_eq("wait_state", seq_state_o, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        boot_mode_i = 2'b10;
        async_reset(3);

        // Power-on sequence.
        run(10);
        mmcm_locked_i = 1'b1;
        run(40);
        calib_done_i = 1'b1;
        run(40);
        check_eq("t1_soc",  soc_rst_no, 1);
        check_eq("t1_boot", boot_mode_o, 2'b10);

        // Short glitch is filtered, long press re-sequences.
        boot_mode_i = 2'b01;
        btn_rst_i = 1'b1; run(5);
        btn_rst_i = 1'b0; run(20);
        check_eq("t2_glitch_soc", soc_rst_no, 1);
        btn_rst_i = 1'b1; run(12);
        btn_rst_i = 1'b0; run(50);
        check_eq("t2_reseq_soc",  soc_rst_no, 1);
        check_eq("t2_reseq_boot", boot_mode_o, 2'b01);

        // Lock loss while running.
        mmcm_locked_i = 1'b0; run(3);
        check_eq("t3_soc",  soc_rst_no, 0);
        check_eq("t3_dram", dram_sys_rst_o, 1);
        run(20);
        check_eq("t3_stuck", seq_state_o <= 3'd1, 1);
        mmcm_locked_i = 1'b1; run(40);

        // Calibration glitch part-way through HOLD.
        calib_done_i = 1'b0; run(25);
        calib_done_i = 1'b1;
        wait_state(3'd3, 10);
        run(10);
        calib_done_i = 1'b0; run(3);
        calib_done_i = 1'b1; run(30);
        check_eq("t4_soc", soc_rst_no, 1);

        // VIO reset coinciding with the HOLD->RUN edge.
        boot_mode_i = 2'b11;
        calib_done_i = 1'b0; run(5);
        calib_done_i = 1'b1;
        wait_state(3'd3, 60);
        run(H - 1);
        vio_rst_i = 1'b1; run(1);
        check_eq("t6_state", seq_state_o, 0);
        check_eq("t6_soc",   soc_rst_no, 0);
        check_eq("t6_boot",  boot_mode_o, 2'b01);
        vio_rst_i = 1'b0; run(40);

        // Calibration never completes.
        calib_done_i = 1'b0; run(205);
`ifndef CHESHIRE_RST_SEQ_CALIB_TIMEOUT_EN
        check_eq("t5_state", seq_state_o, 2);
`endif
        calib_done_i = 1'b1; run(40);

        // Power-on reset in the middle of RUN.
        run(7);
        async_reset(2);
        run(80);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            if (btn_rst_i) begin
                if ($urandom_range(0, 99) < 15) btn_rst_i = 1'b0;
            end else if ($urandom_range(0, 99) < 1) btn_rst_i = 1'b1;
            vio_rst_i   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 299) == 0) mmcm_locked_i = ~mmcm_locked_i;
            if ($urandom_range(0, 149) == 0) calib_done_i  = ~calib_done_i;
            boot_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) async_reset($urandom_range(1, 4));
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
